// File: rtl/cla_seq_subtractor_pkg.sv
// rtl/cla_seq_subtractor_pkg.sv - shared constants and FSM state encoding for the nibble-serial subtractor
package sub_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/cla_seq_subtractor_if.sv
// rtl/cla_seq_subtractor_if.sv - start/done request bus of the subtractor (SUB_OVERFLOW_EN adds V)
interface cla_seq_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic [WIDTH-1:0] D;
  logic             b_out;
  logic             done;
`ifdef SUB_OVERFLOW_EN
  logic             V;

  modport master (output start, A, B, input ready, D, b_out, done, V);
  modport slave  (input start, A, B, output ready, D, b_out, done, V);
`else
  modport master (output start, A, B, input ready, D, b_out, done);
  modport slave  (input start, A, B, output ready, D, b_out, done);
`endif
endinterface

// File: rtl/cla_seq_subtractor_slice.sv
// rtl/cla_seq_subtractor_slice.sv - combinational 4-bit carry-lookahead slice
module cla_slice_4bit
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat function of c_in, no ripple between bit positions.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s = p ^ c;
endmodule

// File: rtl/cla_seq_subtractor.sv
// rtl/cla_seq_subtractor.sv - nibble-serial A-B subtractor top; SUB_OVERFLOW_EN adds signed overflow V
module cla_seq_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_subtractor_if.slave  bus
);
  localparam int N  = WIDTH / NIBBLE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_seq_subtractor: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t                      state;
  logic [CW-1:0]               k;
  logic                        carry;
  logic [WIDTH-1:0]            a_sh;
  logic [WIDTH-1:0]            nb_sh;
  logic [WIDTH-NIBBLE_W-1:0]   res;
  logic [WIDTH-1:0]            d_q;
  logic                        b_q;
  logic [NIBBLE_W-1:0]         slice_s;
  logic                        slice_c;
  logic                        accept;
  logic                        last;
  logic [WIDTH-1:0]            res_next;
`ifdef SUB_OVERFLOW_EN
  logic                        a_msb;
  logic                        b_msb;
  logic                        v_q;
`endif

  // Operands shift right each RUN cycle so the slice always sees the current nibble at bit 0.
  cla_slice_4bit u_slice (
    .a     (a_sh[NIBBLE_W-1:0]),
    .b     (nb_sh[NIBBLE_W-1:0]),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  assign accept   = (state != RUN) && bus.start;
  assign last     = (state == RUN) && (k == CW'(N - 1));
  assign res_next = {slice_s, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      nb_sh <= '0;
      res   <= '0;
      d_q   <= '0;
      b_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      v_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    state <= accept ? RUN : IDLE;
        RUN:     state <= last ? DONE : RUN;
        DONE:    state <= accept ? RUN : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        a_sh  <= bus.A;
        nb_sh <= ~bus.B;
        carry <= 1'b1;
        k     <= '0;
`ifdef SUB_OVERFLOW_EN
        a_msb <= bus.A[WIDTH-1];
        b_msb <= bus.B[WIDTH-1];
`endif
      end else if (state == RUN) begin
        a_sh  <= a_sh >> NIBBLE_W;
        nb_sh <= nb_sh >> NIBBLE_W;
        carry <= slice_c;
        res   <= res_next[WIDTH-1:NIBBLE_W];
        k     <= k + CW'(1);
        if (last) begin
          d_q <= res_next;
          b_q <= ~slice_c;
`ifdef SUB_OVERFLOW_EN
          v_q <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
        end
      end
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.done  = (state == DONE);
  assign bus.D     = d_q;
  assign bus.b_out = b_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.V     = v_q;
`endif
endmodule

// File: tb/tb_cla_seq_subtractor.sv
// tb/tb_cla_seq_subtractor.sv - randomized and directed bench for cla_seq_subtractor (WIDTH 16 and 8)
module tb_cla_seq_subtractor;
  localparam int N16 = 4;
  localparam int N8  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_seq_subtractor_if #(.WIDTH(16)) bus16 ();
  cla_seq_subtractor_if #(.WIDTH(8))  bus8 ();

  cla_seq_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cla_seq_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a request accepted while idle yields A-B exactly N edges later.
  int          m_left;
  logic        m_done;
  logic [15:0] pend_d, exp_d;
  logic        pend_b, exp_b, pend_v, exp_v;

  always @(posedge clk or negedge rst_n) begin : model
    logic acc;
    int   sd;
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0;
      pend_d = '0; pend_b = 1'b0; pend_v = 1'b0;
      exp_d  = '0; exp_b  = 1'b0; exp_v  = 1'b0;
    end else begin
      acc    = (m_left == 0) && bus16.start;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_d = pend_d; exp_b = pend_b; exp_v = pend_v; m_done = 1'b1;
        end
      end
      if (acc) begin
        pend_d = bus16.A - bus16.B;
        pend_b = (bus16.A < bus16.B);
        sd     = int'($signed(bus16.A)) - int'($signed(bus16.B));
        pend_v = (sd > 32767) || (sd < -32768);
        m_left = N16;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready", bus16.ready, (m_left == 0));
      chk("cyc_done",  bus16.done,  m_done);
      chk("cyc_D",     bus16.D,     exp_d);
      chk("cyc_b_out", bus16.b_out, exp_b);
`ifdef SUB_OVERFLOW_EN
      chk("cyc_V",     bus16.V,     exp_v);
`endif
    end
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input string nm,
                      input logic [15:0] ed, input logic eb, input logic ev);
    int n;
    n = 0;
    while (!bus16.ready && n < 50) begin @(negedge clk); n++; end
    bus16.start = 1'b1; bus16.A = a; bus16.B = b;
    @(negedge clk);
    bus16.start = 1'b0;
    n = 0;
    while (!bus16.done && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, N16);
    chk({nm, "_D"}, bus16.D, ed);
    chk({nm, "_b_out"}, bus16.b_out, eb);
`ifdef SUB_OVERFLOW_EN
    chk({nm, "_V"}, bus16.V, ev);
`else
    if (ev === 1'bx) $display("note: undefined overflow expectation for %s", nm);
`endif
  endtask

  initial begin
    int n, prev, pulses;
    bus16.start = 1'b0; bus16.A = '0; bus16.B = '0;
    bus8.start  = 1'b0; bus8.A  = '0; bus8.B  = '0;
    repeat (3) @(negedge clk);
    chk("rst_D", bus16.D, 16'h0);
    chk("rst_b_out", bus16.b_out, 1'b0);
    chk("rst_done", bus16.done, 1'b0);
    chk("rst_ready", bus16.ready, 1'b1);
    chk("rst8_ready", bus8.ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    op16(16'h1234, 16'h0234, "basic",   16'h1000, 1'b0, 1'b0);
    op16(16'h0000, 16'h0001, "zero_m1", 16'hFFFF, 1'b1, 1'b0);
    op16(16'hBEEF, 16'hBEEF, "equal",   16'h0000, 1'b0, 1'b0);
    op16(16'h8000, 16'h0001, "ovf",     16'h7FFF, 1'b0, 1'b1);
    op16(16'h0005, 16'h0003, "small",   16'h0002, 1'b0, 1'b0);

    // Held start with operands scrambled every cycle: only DONE-cycle values are taken.
    @(negedge clk);
    bus16.start = 1'b1; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    prev = -1; pulses = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (bus16.done) begin
        if (prev >= 0) chk("b2b_gap", i - prev, 5);
        prev = i; pulses++;
      end
      bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    end
    chk("b2b_pulses", pulses, 5);
    bus16.start = 1'b0;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus16.start = ($urandom_range(0, 2) == 0);
      bus16.A = 16'($urandom);
      bus16.B = ($urandom_range(0, 7) == 0) ? bus16.A : 16'($urandom);
    end
    bus16.start = 1'b0;

    // Abort mid-operation: outputs clear immediately and no done follows.
    op16(16'h1234, 16'h0234, "pre_rst", 16'h1000, 1'b0, 1'b0);
    bus16.start = 1'b1; bus16.A = 16'h5555; bus16.B = 16'h1111;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_D", bus16.D, 16'h0);
    chk("arst_ready", bus16.ready, 1'b1);
    chk("arst_done", bus16.done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_hold_done", bus16.done, 1'b0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    op16(16'h00FF, 16'h000F, "post_rst", 16'h00F0, 1'b0, 1'b0);

    bus8.start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 20) begin @(negedge clk); n++; end
    chk("w8_latency", n, N8);
    chk("w8_D", bus8.D, 8'hF0);
    chk("w8_b_out", bus8.b_out, 1'b1);
`ifdef SUB_OVERFLOW_EN
    chk("w8_V", bus8.V, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_seq_subtractor.md
Name: cla_seq_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor computing D = A - B, implemented as A + ~B + 1.
- Processes one 4-bit nibble per clock, LSB nibble first, through a single 4-bit carry-lookahead slice.
- Carry is registered between nibbles.
- Serves as the low-area subtract/compare path beside the combinational CLA adders; start/done handshake to the issuing controller.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8 (elaboration error otherwise)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only while ready=1
A      input   WIDTH  minuend; sampled on the accepting edge only
B      input   WIDTH  subtrahend; sampled on the accepting edge only
ready  output  1      block can accept start this cycle
D      output  WIDTH  difference A-B mod 2^WIDTH; registered
b_out  output  1      borrow: 1 iff A < B unsigned (inverted final carry)
done   output  1      one-cycle pulse: D/b_out valid for a new result

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- rst_n=0 (any time, including mid-operation): state=IDLE; D=0, b_out=0, done=0, ready=1; internal nibble counter, carry, and operand registers cleared; the in-flight operation is discarded with no done.
- States and transitions:
  - IDLE: ready=1. start=1 goes to RUN.
  - RUN: ready=0. Stays in RUN for N=WIDTH/4 cycles, then goes to DONE.
  - DONE: ready=1, done=1. start=1 goes to RUN; otherwise goes to IDLE.
- Accepting edge: latch A, ~B; carry register <= 1; nibble index k <= 0.
- RUN cycle k (0..N-1):
  - slice inputs: A[4k+3:4k], ~B[4k+3:4k], carry register.
  - slice sum is written into result nibble k; slice c_out is written to the carry register; k increments.
- Edge ending RUN cycle N-1: D <= full result, b_out <= ~c_out of the final slice, state <= DONE.
- Latency: done is high in the cycle starting exactly N edges after the accepting edge (N=4 for WIDTH=16).
- D and b_out hold their value until the next completion; they do not change while the next operation runs.
- start while ready=0: ignored, not queued; operands are not resampled.
- start in the DONE cycle is accepted (back-to-back). Throughput is one result per N+1 cycles from a held start.
- A or B changing after acceptance has no effect.
- Arithmetic is modulo 2^WIDTH:
  - A==B gives D=0, b_out=0.
  - A=0, B=1 gives D=all ones, b_out=1.

Optional Feature:
SUB_OVERFLOW_EN
- Defined: adds output port V (1 bit, registered, reset 0). V is updated with D at completion. V = signed overflow = (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]). It uses the latched operand MSBs.
- Undefined: port V and its logic do not exist; all other behaviour is identical.

Decomposition:
- Package sub_pkg holds:
  - NIBBLE_W=4
  - state typedef {IDLE, RUN, DONE}, 2-bit encoding IDLE=0, RUN=1, DONE=2
- One sub-module, cla_slice_4bit: purely combinational 4-bit generate/propagate lookahead slice (A, B, c_in -> S, c_out), instantiated once.
- The top holds the FSM, counter, carry register and operand/result registers.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0234, start pulse -> ready low for 4 cycles; done pulse 4 cycles after acceptance; D=0x1000, b_out=0.
- A=0x0000, B=0x0001 -> D=0xFFFF, b_out=1. A=B=0xBEEF -> D=0x0000, b_out=0.
- SUB_OVERFLOW_EN defined: A=0x8000, B=0x0001 -> D=0x7FFF, b_out=0, V=1. A=0x0005, B=0x0003 -> D=0x0002, V=0.
- start held high with new operands presented in each DONE cycle -> results every 5 cycles. Starts and operand changes during RUN are ignored; D stays stable between done pulses.
- rst_n asserted during RUN cycle 2 -> outputs 0 immediately (asynchronous); no done. After release, new start 0x00FF-0x000F -> D=0x00F0.
- WIDTH=8 instance: A=0x10, B=0x20 -> done 2 cycles after acceptance; D=0xF0, b_out=1.
